fifo_synch: RTL and testbench

// Single-clock synchronous FIFO buffering byte data between a producer and a

---
 rtl/fifo_synch_if.sv | 41 ++++
 rtl/fifo_synch.sv | 89 ++++++++
 tb/tb_fifo_synch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_synch_if.sv
// rtl/fifo_synch_if.sv - handshake/data bundle between a producer/consumer and fifo_synch
//
// Purpose: groups the FIFO request, data and flag signals.
// Signals:
//   wn        write request, active high
//   rn        read request, active high
//   data_in   write data, sampled on a clk edge with wn=1
//   data_out  registered read data
//   full      1 when DEPTH entries are stored
//   empty     1 when no entries are stored
// Modports:
//   master  user side (drives wn/rn/data_in)
//   slave   FIFO side (drives data_out/full/empty)
interface fifo_synch_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wn;
    logic                  rn;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;

    modport master (
        output wn,
        output rn,
        output data_in,
        input  data_out,
        input  full,
        input  empty
    );

    modport slave (
        input  wn,
        input  rn,
        input  data_in,
        output data_out,
        output full,
        output empty
    );
endinterface

// File: rtl/fifo_synch.sv
// rtl/fifo_synch.sv - single-clock synchronous FIFO with full/empty flags
//
// Purpose: buffers DATA_WIDTH-bit words between a producer and a consumer in
// one clock domain. Blocked writes (full) and reads (empty) are dropped silently.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous assert, active-low reset
//   bus    fifo_synch_if.slave: wn, rn, data_in in; data_out, full, empty out
// Parameters:
//   DATA_WIDTH  word width in bits
//   DEPTH       number of entries; power of two, >= 2
module fifo_synch #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic         clk,
    input  logic         reset,
    fifo_synch_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic full, empty;
    logic wr_ok, rd_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Acceptance uses the flags as they stand before the edge, so a write on
    // a full FIFO is dropped even when a read frees a slot in the same cycle,
    // and a write into an empty FIFO never reads through.
    assign wr_ok = bus.wn & ~full;
    assign rd_ok = bus.rn & ~empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        // DEPTH is a power of two, so the pointers wrap naturally.
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is deliberately left out of reset; stale contents are never
    // visible because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
endmodule

// File: tb/tb_fifo_synch.sv
// tb/tb_fifo_synch.sv - table-driven scoreboard bench for fifo_synch
module tb_fifo_synch;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;

    fifo_synch_if #(.DATA_WIDTH(DW)) bus ();

    fifo_synch #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wn;
        logic          rn;
        logic [DW-1:0] din;
        int            exp_cnt;
        string         tag;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_dout;
    int            total;
    int            bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic wn, input logic rn, input logic [DW-1:0] din,
                                input int exp_cnt, input string tag);
        vec_t v;
        v.wn = wn; v.rn = rn; v.din = din; v.exp_cnt = exp_cnt; v.tag = tag;
        vecs.push_back(v);
    endfunction

    // One clock cycle: drive on the falling edge, sample 1 time unit after the
    // rising edge. The scoreboard decides acceptance from its own occupancy.
    task automatic step(input logic wn, input logic rn, input logic [DW-1:0] din,
                        input int exp_cnt, input string tag);
        bit wr_ok, rd_ok;
        @(negedge clk);
        bus.wn = wn; bus.rn = rn; bus.data_in = din;
        wr_ok = wn && (sb.size() != DEPTH);
        rd_ok = rn && (sb.size() != 0);
        if (rd_ok) exp_dout = sb.pop_front();
        if (wr_ok) sb.push_back(din);
        @(posedge clk);
        #1;
        chk({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_dout));
        chk({tag, ".empty"},    32'(bus.empty),    32'(exp_cnt == 0));
        chk({tag, ".full"},     32'(bus.full),     32'(exp_cnt == DEPTH));
        chk({tag, ".sb_size"},  32'(sb.size()),    32'(exp_cnt));
    endtask

    initial begin
        total = 0; bad = 0;
        exp_dout = '0;
        bus.wn = 1'b0; bus.rn = 1'b0; bus.data_in = '0;
        reset = 1'b0;

        // fill 1..8, drain
        for (int i = 1; i <= 8; i++) add(1, 0, DW'(i), i, "fill");
        for (int i = 1; i <= 8; i++) add(0, 1, '0, 8 - i, "drain");
        // overflow: 0xFF must be dropped
        for (int i = 0; i < 8; i++) add(1, 0, DW'(8'h10 + i), i + 1, "ovf_fill");
        add(1, 0, 8'hFF, 8, "ovf_write");
        for (int i = 1; i <= 8; i++) add(0, 1, '0, 8 - i, "ovf_drain");
        // underflow and simultaneous r/w on empty
        add(0, 1, '0, 0, "udf_read");
        add(1, 1, 8'hAA, 1, "empty_rw");
        add(0, 1, '0, 0, "read_aa");
        // wrap with concurrency at occupancy 3
        for (int i = 0; i < 3; i++) add(1, 0, DW'(8'h20 + i), i + 1, "pre3");
        for (int i = 0; i < 10; i++) add(1, 1, DW'(8'h30 + i), 3, "conc");
        for (int i = 0; i < 5; i++) add(1, 0, DW'(8'h40 + i), 4 + i, "refill");
        add(1, 1, 8'h50, 7, "full_rw");
        for (int i = 1; i <= 7; i++) add(0, 1, '0, 7 - i, "final_drain");

        // reset held for 2 cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst.empty",    32'(bus.empty),    32'd1);
        chk("rst.full",     32'(bus.full),     32'd0);
        chk("rst.data_out", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, '0, 0, "idle");

        foreach (vecs[i]) step(vecs[i].wn, vecs[i].rn, vecs[i].din, vecs[i].exp_cnt, vecs[i].tag);

        // asynchronous reset mid-operation discards stored data immediately
        step(1, 0, 8'h61, 1, "pre_rst");
        step(1, 0, 8'h62, 2, "pre_rst");
        step(0, 1, '0, 1, "pre_rst_rd");
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst.empty",    32'(bus.empty),    32'd1);
        chk("async_rst.full",     32'(bus.full),     32'd0);
        chk("async_rst.data_out", 32'(bus.data_out), 32'd0);
        sb.delete();
        exp_dout = '0;
        @(negedge clk);
        bus.wn = 1'b0; bus.rn = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, '0, 0, "post_rst_rd");
        step(1, 0, 8'h5A, 1, "post_rst_wr");
        step(0, 1, '0, 0, "post_rst_rd2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
